// File: rtl/date_pkg.sv
// Shared BCD date types, constants and calendar helpers for the date step counter.
package date_pkg;

  typedef struct packed {
    logic [7:0] year;
    logic [7:0] month;
    logic [7:0] day;
  } date_t;

  localparam logic [7:0] MON_JAN = 8'h01;
  localparam logic [7:0] MON_FEB = 8'h02;
  localparam logic [7:0] MON_APR = 8'h04;
  localparam logic [7:0] MON_JUN = 8'h06;
  localparam logic [7:0] MON_SEP = 8'h09;
  localparam logic [7:0] MON_NOV = 8'h11;
  localparam logic [7:0] MON_DEC = 8'h12;

  localparam logic [7:0] DAY_FIRST = 8'h01;
  localparam logic [7:0] DAY_28    = 8'h28;
  localparam logic [7:0] DAY_29    = 8'h29;
  localparam logic [7:0] DAY_30    = 8'h30;
  localparam logic [7:0] DAY_31    = 8'h31;

  localparam logic [7:0] YEAR_MAX  = 8'h99;
  localparam logic [7:0] YEAR_MIN  = 8'h00;

  // Two-digit year divisible by 4 (00 counts as leap), evaluated directly on BCD digits.
  function automatic logic is_leap_bcd(input logic [3:0] year_t, input logic [3:0] year_o);
    if (year_t[0]) return (year_o == 4'd2) || (year_o == 4'd6);
    else           return (year_o == 4'd0) || (year_o == 4'd4) || (year_o == 4'd8);
  endfunction

  function automatic logic [7:0] last_day_bcd(input logic [7:0] month, input logic leap);
    case (month)
      MON_FEB:                            return leap ? DAY_29 : DAY_28;
      MON_APR, MON_JUN, MON_SEP, MON_NOV: return DAY_30;
      default:                            return DAY_31;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer, level debouncer and one-cycle press pulse on the debounced falling edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             db;
  logic             db_prev;
  logic [CNT_W-1:0] cnt;

  // Any return of s2 to the accepted level restarts the hold count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      db      <= 1'b1;
      db_prev <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      db_prev <= db;
      press   <= db_prev & ~db;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/date_step_counter.sv
// Six-digit BCD YY/MM/DD date register that advances one calendar day per debounced button press.
module date_step_counter
  import date_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter logic [7:0]  RST_YEAR        = 8'h80,
  parameter logic [7:0]  RST_MONTH       = 8'h08,
  parameter logic [7:0]  RST_DAY         = 8'h17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic [3:0] year_t,
  output logic [3:0] year_o,
  output logic [3:0] month_t,
  output logic [3:0] month_o,
  output logic [3:0] day_t,
  output logic [3:0] day_o,
  output logic       date_upd
);

  logic       press;
  date_t      cur;
  date_t      nxt;
  logic       leap;
  logic [7:0] last_day;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn),
    .press(press)
  );

  // Next calendar day from the current digits.
  always_comb begin
    nxt      = cur;
    leap     = is_leap_bcd(cur.year[7:4], cur.year[3:0]);
    last_day = last_day_bcd(cur.month, leap);
    if (cur.day != last_day) begin
      nxt.day = bcd_inc8(cur.day);
    end else if (cur.month != MON_DEC) begin
      nxt.day   = DAY_FIRST;
      nxt.month = bcd_inc8(cur.month);
    end else begin
      nxt.day   = DAY_FIRST;
      nxt.month = MON_JAN;
      nxt.year  = (cur.year == YEAR_MAX) ? YEAR_MIN : bcd_inc8(cur.year);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= '{year: RST_YEAR, month: RST_MONTH, day: RST_DAY};
      date_upd <= 1'b0;
    end else begin
      if (press) cur <= nxt;
      date_upd <= press;
    end
  end

  assign year_t  = cur.year[7:4];
  assign year_o  = cur.year[3:0];
  assign month_t = cur.month[7:4];
  assign month_o = cur.month[3:0];
  assign day_t   = cur.day[7:4];
  assign day_o   = cur.day[3:0];

endmodule

// File: tb/tb_date_step_counter.sv
// Directed bench: eight differently-reset counters share one button and reset.
module tb_date_step_counter;

  localparam int NI = 8;
  // Reset dates per instance, instance 0 in the low byte.
  localparam logic [8*NI-1:0] YRS = {8'h00, 8'h99, 8'h80, 8'h80, 8'h80, 8'h81, 8'h80, 8'h80};
  localparam logic [8*NI-1:0] MOS = {8'h02, 8'h12, 8'h08, 8'h08, 8'h09, 8'h02, 8'h02, 8'h08};
  localparam logic [8*NI-1:0] DYS = {8'h28, 8'h31, 8'h19, 8'h31, 8'h30, 8'h28, 8'h28, 8'h17};

  logic clk = 1'b0;
  logic rst_n;
  logic btn;
  logic [3:0] yt [NI];
  logic [3:0] yo [NI];
  logic [3:0] mt [NI];
  logic [3:0] mo [NI];
  logic [3:0] dt [NI];
  logic [3:0] dn [NI];
  logic       upd [NI];

  int vectors = 0;
  int miscompares = 0;
  int upd_cnt [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    date_step_counter #(
      .DEBOUNCE_CYCLES(4),
      .RST_YEAR (YRS[g*8 +: 8]),
      .RST_MONTH(MOS[g*8 +: 8]),
      .RST_DAY  (DYS[g*8 +: 8])
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn     (btn),
      .year_t  (yt[g]),
      .year_o  (yo[g]),
      .month_t (mt[g]),
      .month_o (mo[g]),
      .day_t   (dt[g]),
      .day_o   (dn[g]),
      .date_upd(upd[g])
    );
  end

  function automatic logic [23:0] date_of(input int g);
    return {yt[g], yo[g], mt[g], mo[g], dt[g], dn[g]};
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) upd_cnt[g] += int'(upd[g]);
    end
  endtask

  task automatic clear_upd();
    for (int g = 0; g < NI; g++) upd_cnt[g] = 0;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 1'b1;
    clear_upd();
    tick(3);
    chk("rst_date_u0", date_of(0), 24'h800817);
    chk("rst_upd_u0", 24'(upd[0]), 24'h0);
    chk("rst_date_u6", date_of(6), 24'h991231);
    chk("rst_date_u7", date_of(7), 24'h000228);
    rst_n = 1'b1;
    tick(3);
    chk("post_rst_date_u0", date_of(0), 24'h800817);

    // Short pulses below the debounce length must be ignored.
    clear_upd();
    for (int r = 0; r < 5; r++) begin
      btn = 1'b0;
      tick(3);
      btn = 1'b1;
      tick(4);
    end
    chk("glitch_date_u0", date_of(0), 24'h800817);
    chk("glitch_upd_u0", 24'(upd_cnt[0]), 24'd0);

    // First press with edge-accurate latency check on instance 0.
    clear_upd();
    btn = 1'b0;
    tick(7);
    chk("lat_e7_date", date_of(0), 24'h800817);
    chk("lat_e7_upd", 24'(upd[0]), 24'h0);
    tick(1);
    chk("lat_e8_date", date_of(0), 24'h800818);
    chk("lat_e8_upd", 24'(upd[0]), 24'h1);
    tick(1);
    chk("lat_e9_upd", 24'(upd[0]), 24'h0);
    tick(11);
    chk("held_date_u0", date_of(0), 24'h800818);
    chk("held_upd_cnt", 24'(upd_cnt[0]), 24'd1);
    chk("p1_leap_feb28", date_of(1), 24'h800229);
    chk("p1_nonleap_feb28", date_of(2), 24'h810301);
    chk("p1_sep30", date_of(3), 24'h801001);
    chk("p1_aug31", date_of(4), 24'h800901);
    chk("p1_day19", date_of(5), 24'h800820);
    chk("p1_year_wrap", date_of(6), 24'h000101);
    chk("p1_y00_feb28", date_of(7), 24'h000229);
    btn = 1'b1;
    tick(10);
    chk("release_upd_cnt", 24'(upd_cnt[0]), 24'd1);

    // Second press.
    btn = 1'b0;
    tick(12);
    btn = 1'b1;
    tick(10);
    chk("p2_date_u0", date_of(0), 24'h800819);
    chk("p2_leap_feb29", date_of(1), 24'h800301);
    chk("p2_y00_feb29", date_of(7), 24'h000301);
    chk("p2_jan01", date_of(6), 24'h000102);
    chk("p2_upd_cnt", 24'(upd_cnt[0]), 24'd2);

    // Reset in the middle of a debounce discards the press.
    btn = 1'b0;
    tick(4);
    rst_n = 1'b0;
    btn   = 1'b1;
    tick(2);
    chk("midrst_reset_date", date_of(0), 24'h800817);
    rst_n = 1'b1;
    clear_upd();
    tick(20);
    chk("midrst_date", date_of(0), 24'h800817);
    chk("midrst_upd_cnt", 24'(upd_cnt[0]), 24'd0);

    // Button held through reset release yields exactly one step.
    rst_n = 1'b0;
    btn   = 1'b0;
    tick(2);
    rst_n = 1'b1;
    clear_upd();
    tick(20);
    chk("heldrst_date", date_of(0), 24'h800818);
    chk("heldrst_upd_cnt", 24'(upd_cnt[0]), 24'd1);
    btn = 1'b1;
    tick(10);
    chk("heldrst_release_cnt", 24'(upd_cnt[0]), 24'd1);
    chk("heldrst_u6", date_of(6), 24'h000101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
